// File: rtl/upstream_req_issuer.sv
// Queues client order/maximum commands and issues them one at a time to an upstream
// memory over a level-based write handshake, or as single-cycle reads with a response pulse.
module upstream_req_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int WR_TIMEOUT = 16,
    parameter int MAX_INDEX  = 121
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_index,
    input  logic [15:0] cmd_value,
    input  logic        cmd_is_max,
    input  logic        cmd_is_read,
    output logic [6:0]  up_index,
    output logic [31:0] up_data,
    output logic        up_rw,
    output logic        up_change_max,
    input  logic        up_written,
    input  logic [31:0] up_rd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        err_range,
    output logic        err_timeout,
    output logic [15:0] sent_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(WR_TIMEOUT + 1);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [TW-1:0] tmr_t;

    localparam cnt_t       FULL_CNT = cnt_t'(FIFO_DEPTH);
    localparam tmr_t       TO_LAST  = tmr_t'(WR_TIMEOUT - 1);
    localparam logic [6:0] MAX_IDX  = 7'(MAX_INDEX);

    typedef struct packed {
        logic        is_read;
        logic        is_max;
        logic [6:0]  index;
        logic [15:0] value;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        WR_ISSUE = 3'd2,
        WR_WAIT  = 3'd3,
        GAP      = 3'd4
    } state_t;

    function automatic logic [31:0] pack_wr(input logic is_max, input logic [15:0] value);
        if (is_max) begin
            return {value, 16'h0000};
        end else begin
            return {16'h0000, value};
        end
    endfunction

    cmd_t   r_mem [FIFO_DEPTH];
    ptr_t   r_wr_ptr;
    ptr_t   r_rd_ptr;
    cnt_t   r_count;
    logic   r_cmd_ready;
    state_t r_state;
    tmr_t   r_timer;
    logic   r_cur_is_max;
    logic [15:0] r_cur_value;

    logic [6:0]  r_up_index;
    logic [31:0] r_up_data;
    logic        r_up_rw;
    logic        r_up_change_max;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_err_range;
    logic        r_err_timeout;
    logic [15:0] r_sent_count;

    cmd_t   w_cmd_in;
    cmd_t   w_head;
    logic   w_empty;
    logic   w_bad;
    logic   w_accept;
    logic   w_push;
    logic   w_pop;
    logic   w_wr_done;
    logic   w_wr_to;
    cnt_t   w_count_nxt;
    state_t w_state_nxt;

    // Reads never look at value/type, so only writes can carry an illegal maximum.
    assign w_bad    = (cmd_index > MAX_IDX) ||
                      (!cmd_is_read && cmd_is_max && (cmd_value <= 16'd1));
    assign w_accept = cmd_valid && r_cmd_ready;
    assign w_push   = w_accept && !w_bad;
    assign w_empty  = (r_count == cnt_t'(0));
    assign w_head   = r_mem[r_rd_ptr];
    assign w_cmd_in = '{is_read: cmd_is_read, is_max: cmd_is_max,
                        index: cmd_index, value: cmd_value};

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + cnt_t'(1);
            2'b01:   w_count_nxt = r_count - cnt_t'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Queue pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= ptr_t'(0);
            r_rd_ptr    <= ptr_t'(0);
            r_count     <= cnt_t'(0);
            r_cmd_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            r_count     <= w_count_nxt;
            r_cmd_ready <= (w_count_nxt != FULL_CNT);
        end
    end

    // Queue storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and per-cycle strobes
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_wr_done   = 1'b0;
        w_wr_to     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_head.is_read ? RD_WAIT : WR_ISSUE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RD_WAIT:  w_state_nxt = IDLE;
            WR_ISSUE: w_state_nxt = WR_WAIT;
            WR_WAIT: begin
                // A level left high from before entry is not taken as completion on the first cycle.
                if ((r_timer != tmr_t'(0)) && up_written) begin
                    w_wr_done   = 1'b1;
                    w_state_nxt = GAP;
                end else if (r_timer == TO_LAST) begin
                    w_wr_to     = 1'b1;
                    w_state_nxt = GAP;
                end else begin
                    w_state_nxt = WR_WAIT;
                end
            end
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Cycles spent in WR_WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= tmr_t'(0);
        end else if (r_state == WR_WAIT) begin
            r_timer <= r_timer + tmr_t'(1);
        end else begin
            r_timer <= tmr_t'(0);
        end
    end

    // Upstream, response and error outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_is_max    <= 1'b0;
            r_cur_value     <= 16'h0000;
            r_up_index      <= 7'd0;
            r_up_data       <= 32'h0000_0000;
            r_up_rw         <= 1'b0;
            r_up_change_max <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_data      <= 32'h0000_0000;
            r_err_range     <= 1'b0;
            r_err_timeout   <= 1'b0;
            r_sent_count    <= 16'h0000;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_err_range   <= w_accept && w_bad;
            r_err_timeout <= w_wr_to;
            if (w_pop) begin
                r_up_index   <= w_head.index;
                r_cur_is_max <= w_head.is_max;
                r_cur_value  <= w_head.value;
            end
            if (r_state == RD_WAIT) begin
                r_rsp_data  <= up_rd_data;
                r_rsp_valid <= 1'b1;
            end
            if (r_state == WR_ISSUE) begin
                r_up_data       <= pack_wr(r_cur_is_max, r_cur_value);
                r_up_change_max <= r_cur_is_max;
                r_up_rw         <= 1'b1;
            end else if (w_wr_done || w_wr_to) begin
                r_up_rw         <= 1'b0;
                r_up_change_max <= 1'b0;
            end
            if (w_wr_done) begin
                r_sent_count <= r_sent_count + 16'd1;
            end
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign up_index      = r_up_index;
    assign up_data       = r_up_data;
    assign up_rw         = r_up_rw;
    assign up_change_max = r_up_change_max;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign err_range     = r_err_range;
    assign err_timeout   = r_err_timeout;
    assign sent_count    = r_sent_count;

endmodule

// File: tb/tb_upstream_req_issuer.sv
// Scoreboard bench for upstream_req_issuer: expected issues/responses are queued at stimulus
// time and popped by a monitor; an upstream responder answers writes after a set latency.
module tb_upstream_req_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_index;
    logic [15:0] cmd_value;
    logic        cmd_is_max;
    logic        cmd_is_read;
    logic [6:0]  up_index;
    logic [31:0] up_data;
    logic        up_rw;
    logic        up_change_max;
    logic        up_written = 1'b0;
    logic [31:0] up_rd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        err_range;
    logic        err_timeout;
    logic [15:0] sent_count;

    always #5 clk = ~clk;

    upstream_req_issuer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
        .cmd_value(cmd_value), .cmd_is_max(cmd_is_max), .cmd_is_read(cmd_is_read),
        .up_index(up_index), .up_data(up_data), .up_rw(up_rw),
        .up_change_max(up_change_max), .up_written(up_written), .up_rd_data(up_rd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err_range(err_range),
        .err_timeout(err_timeout), .sent_count(sent_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic        rd;
        logic [6:0]  idx;
        logic [31:0] data;
        logic        chmax;
    } exp_t;

    exp_t iss_q[$];
    int   err_q[$];
    int   to_q[$];

    // Upstream responder: raises up_written once up_rw has been high for wr_lat+1 cycles (never if wr_lat < 0)
    int wr_lat = 3;
    int hi_n   = 0;
    always @(negedge clk) begin
        hi_n       <= up_rw ? hi_n + 1 : 0;
        up_written <= up_rw && (wr_lat >= 0) && (hi_n + 1 > wr_lat);
    end

    // Monitor: pops the scoreboard on every write issue, read response and error pulse
    logic        prev_rw = 1'b0;
    logic [6:0]  hold_idx;
    logic [31:0] hold_data;
    logic        hold_chmax;
    int          cyc = 0;
    int          rise_cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (up_rw && !prev_rw) begin
                rise_cyc = cyc;
                check("write_expected", 32'(iss_q.size() > 0), 32'd1);
                if (iss_q.size() > 0) begin
                    e = iss_q.pop_front();
                    check("write_kind", 32'(e.rd), 32'd0);
                    check("write_index", 32'(up_index), 32'(e.idx));
                    check("write_data", up_data, e.data);
                    check("write_change_max", 32'(up_change_max), 32'(e.chmax));
                end
                hold_idx   = up_index;
                hold_data  = up_data;
                hold_chmax = up_change_max;
            end else if (up_rw && prev_rw) begin
                check("write_stable", 32'((up_index == hold_idx) && (up_data == hold_data) &&
                                          (up_change_max == hold_chmax)), 32'd1);
            end
            if (rsp_valid) begin
                check("read_expected", 32'(iss_q.size() > 0), 32'd1);
                if (iss_q.size() > 0) begin
                    e = iss_q.pop_front();
                    check("read_kind", 32'(e.rd), 32'd1);
                    check("read_index", 32'(up_index), 32'(e.idx));
                    check("read_data", rsp_data, e.data);
                end
            end
            if (err_range) begin
                check("err_range_expected", 32'(err_q.size() > 0), 32'd1);
                if (err_q.size() > 0) begin
                    void'(err_q.pop_front());
                end
            end
            if (err_timeout) begin
                check("err_timeout_expected", 32'(to_q.size() > 0), 32'd1);
                if (to_q.size() > 0) begin
                    void'(to_q.pop_front());
                    check("err_timeout_latency", 32'(cyc - rise_cyc), 32'd16);
                end
            end
        end
        prev_rw = up_rw;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] idx, input logic [15:0] val, input logic mx,
                        input logic rd, input logic bad);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check("send_ready", 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_index   = idx;
        cmd_value   = val;
        cmd_is_max  = mx;
        cmd_is_read = rd;
        tick();
        cmd_valid = 1'b0;
        if (bad) begin
            check("err_range_next_cycle", 32'(err_range), 32'd1);
        end
    endtask

    task automatic wait_wr(output int hi);
        int n = 0;
        hi = 0;
        while (!up_rw && n < 100) begin
            tick();
            n++;
        end
        while (up_rw && hi < 100) begin
            tick();
            hi++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hi;
        int n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_index = 7'd0; cmd_value = 16'h0000;
        cmd_is_max = 1'b0; cmd_is_read = 1'b0; up_rd_data = 32'h0000_0000;
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_up_rw", 32'(up_rw), 32'd0);
        check("rst_up_change_max", 32'(up_change_max), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_err_range", 32'(err_range), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        check("rst_up_index", 32'(up_index), 32'd0);
        check("rst_up_data", up_data, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_sent_count", 32'(sent_count), 32'd0);
        rst = 1'b0;
        tick();

        // Accumulate, completion 3 cycles after up_rw rises
        wr_lat = 3;
        iss_q.push_back('{1'b0, 7'd5, 32'h0000_0010, 1'b0});
        send(7'd5, 16'h0010, 1'b0, 1'b0, 1'b0);
        wait_wr(hi);
        check("acc_rw_high_cycles", 32'(hi), 32'd4);
        check("acc_sent_count", 32'(sent_count), 32'd1);

        // Max update with up_written already high on WR_WAIT entry, then illegal and minimum-legal maxima
        wr_lat = 0;
        iss_q.push_back('{1'b0, 7'd7, 32'h0100_0000, 1'b1});
        send(7'd7, 16'h0100, 1'b1, 1'b0, 1'b0);
        wait_wr(hi);
        check("max_rw_high_cycles", 32'(hi), 32'd2);
        check("max_sent_count", 32'(sent_count), 32'd2);
        err_q.push_back(1);
        send(7'd7, 16'h0001, 1'b1, 1'b0, 1'b1);
        repeat (6) tick();
        check("bad_max_no_write", 32'(sent_count), 32'd2);
        iss_q.push_back('{1'b0, 7'd8, 32'h0002_0000, 1'b1});
        send(7'd8, 16'h0002, 1'b1, 1'b0, 1'b0);
        wait_wr(hi);
        check("max2_sent_count", 32'(sent_count), 32'd3);

        // Fill queue behind a slow write; out-of-range index must not occupy a slot
        wr_lat = 12;
        up_rd_data = 32'hCAFE_0001;
        iss_q.push_back('{1'b0, 7'd20, 32'h0000_0AAA, 1'b0});
        send(7'd20, 16'h0AAA, 1'b0, 1'b0, 1'b0);
        iss_q.push_back('{1'b0, 7'd21, 32'h0000_0011, 1'b0});
        send(7'd21, 16'h0011, 1'b0, 1'b0, 1'b0);
        iss_q.push_back('{1'b1, 7'd22, 32'hCAFE_0001, 1'b0});
        send(7'd22, 16'h0000, 1'b0, 1'b1, 1'b0);
        iss_q.push_back('{1'b0, 7'd23, 32'h1234_0000, 1'b1});
        send(7'd23, 16'h1234, 1'b1, 1'b0, 1'b0);
        err_q.push_back(1);
        send(7'd122, 16'h0001, 1'b0, 1'b0, 1'b1);
        check("range_reject_ready_high", 32'(cmd_ready), 32'd1);
        iss_q.push_back('{1'b0, 7'd24, 32'h0000_FFFF, 1'b0});
        send(7'd24, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        check("full_ready_low", 32'(cmd_ready), 32'd0);
        iss_q.push_back('{1'b1, 7'd25, 32'hCAFE_0001, 1'b0});
        send(7'd25, 16'h0000, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (iss_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check("fill_drained", 32'(iss_q.size()), 32'd0);
        check("fill_sent_count", 32'(sent_count), 32'd7);

        // Write that never completes, followed by one that does
        wr_lat = -1;
        iss_q.push_back('{1'b0, 7'd30, 32'h0000_0055, 1'b0});
        to_q.push_back(1);
        send(7'd30, 16'h0055, 1'b0, 1'b0, 1'b0);
        iss_q.push_back('{1'b0, 7'd31, 32'h0000_0066, 1'b0});
        send(7'd31, 16'h0066, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!err_timeout && n < 100) begin
            tick();
            n++;
        end
        check("timeout_seen", 32'(err_timeout), 32'd1);
        check("timeout_sent_count", 32'(sent_count), 32'd7);
        wr_lat = 2;
        wait_wr(hi);
        check("after_timeout_rw_high", 32'(hi), 32'd3);
        check("after_timeout_sent_count", 32'(sent_count), 32'd8);

        // Read latency: response two cycles after the pop cycle
        tick();
        up_rd_data = 32'h0064_0020;
        iss_q.push_back('{1'b1, 7'd3, 32'h0064_0020, 1'b0});
        send(7'd3, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("read_pop_cycle_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        check("read_wait_cycle_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        check("read_rsp_valid", 32'(rsp_valid), 32'd1);
        check("read_rsp_data", rsp_data, 32'h0064_0020);
        repeat (3) tick();

        // Reset in the middle of a write with another command still queued
        wr_lat = -1;
        iss_q.push_back('{1'b0, 7'd40, 32'h0000_0077, 1'b0});
        send(7'd40, 16'h0077, 1'b0, 1'b0, 1'b0);
        send(7'd41, 16'h0088, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!up_rw && n < 20) begin
            tick();
            n++;
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midwrite_rst_rw_low", 32'(up_rw), 32'd0);
        check("midwrite_rst_ready", 32'(cmd_ready), 32'd1);
        check("midwrite_rst_sent_count", 32'(sent_count), 32'd0);
        rst = 1'b0;
        wr_lat = 1;
        repeat (30) tick();
        check("post_rst_sent_count", 32'(sent_count), 32'd0);

        check("end_issue_queue_empty", 32'(iss_q.size()), 32'd0);
        check("end_err_queue_empty", 32'(err_q.size()), 32'd0);
        check("end_timeout_queue_empty", 32'(to_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
